// File: rtl/imem_load_run_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot/run sequencer:
// default widths, counter-width derivation and the state encoding.
package imem_load_run_ctrl_pkg;

    localparam int DSIZE_DEF     = 32;
    localparam int ISIZE_DEF     = 32;
    localparam int MEM_DEPTH_DEF = 256;

    // Load-count width must hold MEM_DEPTH itself, hence the extra bit.
    function automatic int cw_for_depth(input int depth);
        return $clog2(depth) + 1;
    endfunction

    localparam int CW_DEF = cw_for_depth(MEM_DEPTH_DEF);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ARM  = 3'd2,
        ST_RUN  = 3'd3,
        ST_DONE = 3'd4
    } ctrl_state_e;

endpackage

// File: rtl/ctrl_sat_counter.sv
// Up-counter with synchronous clear, count enable and saturation at all-ones.
module ctrl_sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_load_run_ctrl.sv
// Streams a program into instruction memory with the pipeline held in reset,
// then releases the pipeline for a cycle budget or until a halt request.
module imem_load_run_ctrl
    import imem_load_run_ctrl_pkg::*;
#(
    parameter int DSIZE     = DSIZE_DEF,
    parameter int ISIZE     = ISIZE_DEF,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF,
    parameter int CW        = CW_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_start,
    input  logic [CW-1:0]    ld_count,
    input  logic [15:0]      run_cycles,
    input  logic             ld_valid,
    input  logic [DSIZE-1:0] ld_data,
    output logic             ld_ready,
    input  logic             halt_req,
    output logic             imem_wen,
    output logic [ISIZE-1:0] imem_addr,
    output logic [DSIZE-1:0] imem_wdata,
    output logic             pipe_hold,
    output logic             busy,
    output logic             done,
    output logic [31:0]      cycle_cnt,
    output logic [2:0]       ctrl_state
);

    ctrl_state_e   state_reg;
    ctrl_state_e   state_next;
    logic [CW-1:0] count_reg;
    logic [15:0]   run_reg;
    logic [CW-1:0] ptr;
    logic [CW-1:0] ld_count_clamped;

    logic start_ok;
    logic xfer;
    logic last_word;
    logic budget_hit;
    logic ptr_clr;

    assign start_ok  = load_start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
    assign xfer      = (state_reg == ST_LOAD) && ld_ready && ld_valid && !halt_req;
    assign last_word = (ptr == count_reg - CW'(1));
    assign ptr_clr   = start_ok || ((state_reg == ST_LOAD) && halt_req);

    // Compare against budget-1 so DONE lands on the edge where cycle_cnt reaches the budget.
    assign budget_hit = (run_reg != 16'd0) && (cycle_cnt == ({16'd0, run_reg} - 32'd1));

    assign ld_count_clamped = (ld_count > CW'(MEM_DEPTH)) ? CW'(MEM_DEPTH) : ld_count;

    assign ctrl_state = state_reg;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    state_next = (ld_count != '0) ? ST_LOAD : ST_ARM;
                end
            end
            ST_LOAD: begin
                if (halt_req) begin
                    state_next = ST_IDLE;
                end else if (xfer && last_word) begin
                    state_next = ST_ARM;
                end
            end
            ST_ARM: state_next = ST_RUN;
            ST_RUN: begin
                if (halt_req || budget_hit) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            ld_ready   <= 1'b0;
            imem_wen   <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            pipe_hold  <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            count_reg  <= '0;
            run_reg    <= '0;
        end else begin
            state_reg <= state_next;
            ld_ready  <= (state_next == ST_LOAD);
            pipe_hold <= (state_next != ST_RUN);
            busy      <= (state_next == ST_LOAD) || (state_next == ST_ARM) || (state_next == ST_RUN);
            done      <= (state_next == ST_DONE);
            // Write port lags the accepted word by one cycle; the last one lands in ARM.
            imem_wen  <= xfer;
            if (xfer) begin
                imem_addr  <= ISIZE'(ptr);
                imem_wdata <= ld_data;
            end
            if (start_ok) begin
                count_reg <= ld_count_clamped;
                run_reg   <= run_cycles;
            end
        end
    end

    ctrl_sat_counter #(.WIDTH(CW)) u_ptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (ptr_clr),
        .en    (xfer),
        .count (ptr)
    );

    ctrl_sat_counter #(.WIDTH(32)) u_cycle (
        .clk   (clk),
        .rst   (rst),
        .clr   (start_ok),
        .en    (state_reg == ST_RUN),
        .count (cycle_cnt)
    );

endmodule

// File: tb/tb_imem_load_run_ctrl.sv
// Directed bench for the boot/run sequencer: load, gapped load, halt in RUN,
// abort in LOAD, async reset mid-RUN and over-depth load clamping.
module tb_imem_load_run_ctrl;

    localparam int DSIZE     = 32;
    localparam int ISIZE     = 32;
    localparam int MEM_DEPTH = 256;
    localparam int CW        = 9;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             load_start = 1'b0;
    logic [CW-1:0]    ld_count = '0;
    logic [15:0]      run_cycles = '0;
    logic             ld_valid = 1'b0;
    logic [DSIZE-1:0] ld_data = '0;
    logic             halt_req = 1'b0;
    logic             ld_ready;
    logic             imem_wen;
    logic [ISIZE-1:0] imem_addr;
    logic [DSIZE-1:0] imem_wdata;
    logic             pipe_hold;
    logic             busy;
    logic             done;
    logic [31:0]      cycle_cnt;
    logic [2:0]       ctrl_state;

    int n_checks = 0;
    int n_fail   = 0;

    int               wr_total       = 0;
    int               hold_low_total = 0;
    int               max_addr       = -1;
    logic [2:0]       last_wr_state  = 3'd0;
    logic [ISIZE-1:0] wr_addr_q[$];
    logic [DSIZE-1:0] wr_data_q[$];

    always #5 clk = ~clk;

    imem_load_run_ctrl #(
        .DSIZE(DSIZE), .ISIZE(ISIZE), .MEM_DEPTH(MEM_DEPTH), .CW(CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .ld_count   (ld_count),
        .run_cycles (run_cycles),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .halt_req   (halt_req),
        .imem_wen   (imem_wen),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .pipe_hold  (pipe_hold),
        .busy       (busy),
        .done       (done),
        .cycle_cnt  (cycle_cnt),
        .ctrl_state (ctrl_state)
    );

    // Write-port and hold monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst && imem_wen) begin
            wr_total++;
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
            last_wr_state = ctrl_state;
            if (int'(imem_addr) > max_addr) max_addr = int'(imem_addr);
        end
        if (rst && !pipe_hold) hold_low_total++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (!done && k < budget) begin
            tick();
            k++;
        end
        check(tag, {63'd0, done}, 64'd1);
    endtask

    task automatic start(input logic [CW-1:0] cnt, input logic [15:0] runc);
        load_start = 1'b1;
        ld_count   = cnt;
        run_cycles = runc;
        tick();
        load_start = 1'b0;
    endtask

    initial begin
        logic [31:0] words [3];
        logic [4:0]  pat;
        int base_w;
        int base_h;
        int k;
        int bad;

        words[0] = 32'h2001_0005;
        words[1] = 32'h2002_0003;
        words[2] = 32'h0022_1800;

        // Reset values
        #12;
        check("rst_state", ctrl_state, 3'd0);
        check("rst_pipe_hold", pipe_hold, 1'b1);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_wen", imem_wen, 1'b0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_cycle_cnt", cycle_cnt, 32'd0);
        rst = 1'b1;
        tick();

        // 1: three-word load, budget 5
        base_w = wr_total;
        base_h = hold_low_total;
        ld_valid = 1'b1;
        ld_data  = words[0];
        start(9'd3, 16'd5);
        check("t1_state_load", ctrl_state, 3'd1);
        check("t1_ld_ready", ld_ready, 1'b1);
        check("t1_busy", busy, 1'b1);
        check("t1_no_wen_yet", imem_wen, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_wen", imem_wen, 1'b1);
            check("t1_addr", imem_addr, 32'(i));
            check("t1_wdata", imem_wdata, words[i]);
            if (i < 2) ld_data = words[i + 1];
        end
        ld_valid = 1'b0;
        check("t1_state_arm", ctrl_state, 3'd2);
        check("t1_arm_ready", ld_ready, 1'b0);
        check("t1_arm_hold", pipe_hold, 1'b1);
        tick();
        check("t1_state_run", ctrl_state, 3'd3);
        check("t1_run_hold", pipe_hold, 1'b0);
        check("t1_run_cnt0", cycle_cnt, 32'd0);
        tick();
        check("t1_run_cnt1", cycle_cnt, 32'd1);
        wait_done("t1_done", 20);
        check("t1_cycle_cnt", cycle_cnt, 32'd5);
        check("t1_state_done", ctrl_state, 3'd4);
        check("t1_hold_back", pipe_hold, 1'b1);
        check("t1_hold_low_cycles", hold_low_total - base_h, 64'd5);
        check("t1_writes", wr_total - base_w, 64'd3);

        // 2: same load with gapped valid
        base_w = wr_total;
        pat = 5'b10101;
        start(9'd3, 16'd5);
        check("t2_cnt_cleared", cycle_cnt, 32'd0);
        check("t2_done_clear", done, 1'b0);
        k = 0;
        for (int i = 0; i < 5; i++) begin
            ld_valid = pat[i];
            ld_data  = pat[i] ? words[k] : 32'hDEAD_BEEF;
            tick();
            check("t2_wen", imem_wen, pat[i]);
            if (pat[i]) begin
                check("t2_addr", imem_addr, 32'(k));
                check("t2_wdata", imem_wdata, words[k]);
                k++;
            end
        end
        ld_valid = 1'b0;
        check("t2_state_arm", ctrl_state, 3'd2);
        wait_done("t2_done", 20);
        check("t2_writes", wr_total - base_w, 64'd3);
        check("t2_cycle_cnt", cycle_cnt, 32'd5);

        // 3: unlimited run, halt on the 7th RUN cycle
        start(9'd0, 16'd0);
        check("t3_state_arm", ctrl_state, 3'd2);
        tick();
        check("t3_state_run", ctrl_state, 3'd3);
        repeat (6) tick();
        check("t3_cnt6", cycle_cnt, 32'd6);
        check("t3_hold_low", pipe_hold, 1'b0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t3_state_done", ctrl_state, 3'd4);
        check("t3_cycle_cnt", cycle_cnt, 32'd7);
        check("t3_hold_back", pipe_hold, 1'b1);
        check("t3_done", done, 1'b1);

        // 4: abort after 2 of 4 words
        base_w = wr_total;
        ld_valid = 1'b1;
        ld_data  = 32'h1111_1111;
        start(9'd4, 16'd0);
        tick();
        check("t4_addr0", imem_addr, 32'd0);
        ld_data = 32'h2222_2222;
        tick();
        check("t4_wen1", imem_wen, 1'b1);
        check("t4_addr1", imem_addr, 32'd1);
        check("t4_wdata1", imem_wdata, 32'h2222_2222);
        halt_req = 1'b1;
        ld_data  = 32'h3333_3333;
        tick();
        halt_req = 1'b0;
        ld_valid = 1'b0;
        check("t4_state_idle", ctrl_state, 3'd0);
        check("t4_ld_ready", ld_ready, 1'b0);
        check("t4_done", done, 1'b0);
        check("t4_busy", busy, 1'b0);
        check("t4_no_wen", imem_wen, 1'b0);
        tick();
        check("t4_writes", wr_total - base_w, 64'd2);

        // 5: async reset mid-RUN, then run existing memory
        start(9'd0, 16'd0);
        tick();
        repeat (3) tick();
        check("t5_cnt3", cycle_cnt, 32'd3);
        #1 rst = 1'b0;
        #1;
        check("t5_rst_hold", pipe_hold, 1'b1);
        check("t5_rst_cnt", cycle_cnt, 32'd0);
        check("t5_rst_state", ctrl_state, 3'd0);
        #1 rst = 1'b1;
        tick();
        base_w = wr_total;
        start(9'd0, 16'd0);
        check("t5_state_arm", ctrl_state, 3'd2);
        check("t5_arm_hold", pipe_hold, 1'b1);
        tick();
        check("t5_state_run", ctrl_state, 3'd3);
        check("t5_run_hold", pipe_hold, 1'b0);
        check("t5_no_writes", wr_total - base_w, 64'd0);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t5_state_done", ctrl_state, 3'd4);

        // 6: over-depth load clamps to MEM_DEPTH words
        base_w = wr_total;
        ld_valid = 1'b1;
        ld_data  = 32'hC0DE_0000;
        start(9'd300, 16'd1);
        for (int i = 0; i < MEM_DEPTH; i++) begin
            tick();
            ld_data = 32'hC0DE_0000 | 32'(i + 1);
        end
        check("t6_state_arm", ctrl_state, 3'd2);
        check("t6_ld_ready", ld_ready, 1'b0);
        check("t6_last_addr", imem_addr, 32'd255);
        tick();
        ld_valid = 1'b0;
        check("t6_state_run", ctrl_state, 3'd3);
        wait_done("t6_done", 5);
        check("t6_cycle_cnt", cycle_cnt, 32'd1);
        check("t6_writes", wr_total - base_w, 64'd256);
        check("t6_max_addr", max_addr, 64'd255);
        check("t6_last_wr_in_arm", last_wr_state, 3'd2);
        bad = 0;
        for (int i = 0; i < MEM_DEPTH; i++) begin
            if ((base_w + i) < wr_addr_q.size()) begin
                if (wr_addr_q[base_w + i] !== 32'(i)) bad++;
                if (wr_data_q[base_w + i] !== (32'hC0DE_0000 | 32'(i))) bad++;
            end else begin
                bad++;
            end
        end
        check("t6_addr_data_seq", bad, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_load_run_ctrl.md
Name: imem_load_run_ctrl

Overview:
- Boot/run sequencer for the 4-stage pipelined core. The core's instruction memory write enable is otherwise tied low.
- Accepts a program as a valid/ready word stream and writes it into instruction memory starting at word address 0, holding the pipeline in reset while it loads.
- Releases the pipeline, counts execution cycles, and freezes the pipeline again on a cycle budget or a halt request.
- Sits between the testbench/host loader and the memory write port and pipeline reset of the core.

Parameters:
- DSIZE, 32, instruction/data word width (matches the core's DSIZE).
- ISIZE, 32, instruction address width (matches the core's ISIZE).
- MEM_DEPTH, 256, instruction memory depth in words.
- CW, 9, width of ld_count; must equal log2(MEM_DEPTH)+1.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- load_start  in  1  one-cycle pulse that begins a program load.
- ld_count  in  CW  number of words to load; latched when load_start is accepted; values above MEM_DEPTH are clamped to MEM_DEPTH.
- run_cycles  in  16  execution budget in cycles; latched with load_start; 0 means unlimited.
- ld_valid  in  1  loader word valid.
- ld_data  in  DSIZE  loader word.
- ld_ready  out  1  controller accepts a word this cycle.
- halt_req  in  1  level; stops RUN, or aborts LOAD.
- imem_wen  out  1  instruction memory write enable.
- imem_addr  out  ISIZE  instruction memory word address.
- imem_wdata  out  DSIZE  instruction memory write data.
- pipe_hold  out  1  1 = hold pipeline (PC, IF_ID, ID_EXE, EXE_WB) in reset.
- busy  out  1  in LOAD, ARM or RUN.
- done  out  1  in DONE.
- cycle_cnt  out  32  RUN cycles elapsed.
- ctrl_state  out  3  current state encoding.

Behaviour:
- Reset (rst=0, async): state IDLE, pipe_hold=1, ld_ready=0, imem_wen=0, imem_addr=0, imem_wdata=0, busy=0, done=0, cycle_cnt=0.
- States: IDLE=0, LOAD=1, ARM=2, RUN=3, DONE=4.
- IDLE:
  - pipe_hold=1.
  - load_start with ld_count>0 -> LOAD; word pointer and cycle_cnt cleared.
  - load_start with ld_count=0 -> ARM (runs the existing memory contents).
- LOAD:
  - ld_ready=1.
  - A transfer occurs when ld_valid && ld_ready.
  - Write is registered, latency 1: the cycle after a transfer, imem_wen=1, imem_addr=pointer, imem_wdata=word. The pointer then increments.
  - imem_wen=0 in every cycle not following a transfer.
  - On the transfer of word ld_count-1, state -> ARM and ld_ready=0 from the next cycle.
- ARM:
  - Exactly one cycle; carries the final write pulse; pipe_hold=1.
  - Guarantees the last word is in memory before PC leaves reset. -> RUN.
- RUN:
  - pipe_hold=0.
  - cycle_cnt increments by 1 per cycle, saturating at 2^32-1. The first RUN cycle shows cycle_cnt=1 at its end.
  - -> DONE when run_cycles!=0 and cycle_cnt==run_cycles (registered compare; exactly run_cycles cycles with pipe_hold=0).
  - -> DONE when halt_req=1 is sampled; halt has priority when both conditions coincide.
- DONE:
  - pipe_hold=1, done=1, cycle_cnt frozen.
  - load_start -> LOAD/ARM, same rules as IDLE; cycle_cnt is cleared.
- load_start is ignored in LOAD, ARM and RUN.
- halt_req in LOAD:
  - Abort -> IDLE next cycle; ld_ready=0.
  - A write already registered from the previous transfer still completes.
  - The pointer is discarded.
- halt_req in ARM is held off until RUN; it is then sampled in the first RUN cycle, giving 1 RUN cycle.
- imem_addr is a word index zero-extended to ISIZE. The pointer never exceeds MEM_DEPTH-1 because of the clamp.
- ld_valid while ld_ready=0: no transfer and no side effect.
- Async reset asserted mid-LOAD or mid-RUN: immediate return to reset values. Memory contents are not cleared.

Decomposition:
- Shared package/include: the five state encodings, DSIZE/ISIZE defines (from the existing define include), and CW derivation.
- One natural sub-module: ctrl_sat_counter. A WIDTH-parameterised counter with clear, enable and saturation, used for cycle_cnt and the load pointer.

Test Plan:
1. Reset then load_start, ld_count=3, run_cycles=5; stream 0x20010005, 0x20020003, 0x00221800 with ld_valid always high.
   - Required: imem_wen pulses at addresses 0,1,2 one cycle after each transfer; ARM one cycle; pipe_hold=0 for exactly 5 cycles; done=1; cycle_cnt=5.
2. Same load with ld_valid toggling 1,0,1,0,1.
   - Required: exactly 3 writes; addresses contiguous 0..2; no imem_wen in gap cycles.
3. run_cycles=0; assert halt_req on the 7th RUN cycle.
   - Required: DONE next cycle; cycle_cnt=7; pipe_hold back to 1.
4. halt_req after 2 of 4 words.
   - Required: second write still completes at address 1; state IDLE; ld_ready=0; done=0.
5. Drop rst mid-RUN (cycle_cnt=3).
   - Required: same-cycle pipe_hold=1, cycle_cnt=0, state IDLE. A subsequent load_start with ld_count=0 goes IDLE->ARM->RUN with no imem_wen.
6. ld_count=300 with MEM_DEPTH=256.
   - Required: exactly 256 writes, addresses 0..255; the final write is in ARM; imem_addr never reaches 256.
